// File: rtl/cksum_checker.sv
// -----------------------------------------------------------------------------
// cksum_checker
//   Receive-side checker for two-byte codewords (data byte, then check byte).
//   It recomputes the per-byte XOR check value from the data byte, compares it
//   with the received check byte, and presents the data byte, syndrome and
//   error flag through a one-entry registered output stage with valid/ready
//   flow control. Framing violations give a one-cycle frm_err pulse.
//
//   Optional feature macro: CHECKER_ERR_CNT_EN
//     defined   : 16-bit saturating count of codewords with out_err=1,
//                 cleared synchronously by err_clr (clear wins).
//     undefined : err_cnt tied to 0, err_clr ignored, no counter flops.
//
// Ports
//   clk       in   1  rising-edge clock
//   nrst      in   1  asynchronous active-low reset
//   in_valid  in   1  input beat valid
//   in_first  in   1  1 = data byte, 0 = check byte
//   in_byte   in   8  input byte
//   in_ready  out  1  beat accepted when in_valid & in_ready
//   out_valid out  1  result valid
//   out_ready in   1  result consumed when out_valid & out_ready
//   out_data  out  8  received data byte
//   out_syn   out  8  received check ^ f(data)
//   out_err   out  1  |out_syn
//   frm_err   out  1  one-cycle pulse after a framing violation
//   err_clr   in   1  synchronous clear of err_cnt
//   err_cnt   out 16  saturating codeword-error count
// -----------------------------------------------------------------------------
module cksum_checker (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  input  logic        in_first,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  out_syn,
  output logic        out_err,
  output logic        frm_err,
  input  logic        err_clr,
  output logic [15:0] err_cnt
);

  typedef enum logic {
    S_DATA  = 1'b0,   // awaiting a data byte
    S_CHECK = 1'b1    // data byte held in data_q
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q;
  logic       accept;
  logic       load;
  logic       frame_bad;

  // Check value generator: each output bit is the XOR of a fixed subset of
  // data bits.
  function automatic logic [7:0] chk_f(input logic [7:0] v);
    logic [7:0] c;
    c[7] = v[3] ^ v[2] ^ v[5];
    c[6] = v[2] ^ v[1] ^ v[4] ^ v[7];
    c[5] = v[1] ^ v[7] ^ v[0] ^ v[3] ^ v[6];
    c[4] = v[7] ^ v[0] ^ v[3] ^ v[6];
    c[3] = v[3] ^ v[7] ^ v[6];
    c[2] = v[2] ^ v[6] ^ v[5];
    c[1] = v[1] ^ v[5] ^ v[4] ^ v[7];
    c[0] = v[0] ^ v[4] ^ v[3] ^ v[6];
    return c;
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_DATA;
    else       state_q <= state_d;
  end

  // Next-state: any accepted data byte leads to S_CHECK (a repeated data byte
  // simply replaces the held one); any accepted check byte leads to S_DATA.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    if (accept) state_d = in_first ? S_CHECK : S_DATA;
  end

  // Output / handshake decode.
  always_comb begin
    in_ready  = 1'b1;
    if (state_q == S_CHECK) in_ready = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    load      = accept && !in_first && (state_q == S_CHECK);
    // Violation: data byte while one is already held, or check byte with
    // nothing held.
    frame_bad = accept && (in_first == (state_q == S_CHECK));
  end

  // Datapath and output stage. In S_CHECK in_ready guarantees the stage is
  // free or being drained in this cycle, so a load never loses a result.
  // NOTE: the data registers carry a reset too, because their reset values
  // are externally visible on out_data/out_syn.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_syn   <= '0;
      out_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      frm_err <= frame_bad;
      if (accept && in_first) data_q <= in_byte;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= data_q;
        out_syn   <= in_byte ^ chk_f(data_q);
        out_err   <= |(in_byte ^ chk_f(data_q));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CHECKER_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        load_err;

  assign load_err = load && |(in_byte ^ chk_f(data_q));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                  err_cnt_q <= '0;
    else if (err_clr)                           err_cnt_q <= '0;
    else if (load_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_cksum_checker.sv
// -----------------------------------------------------------------------------
// tb_cksum_checker
//   Self-checking bench for cksum_checker: directed scenarios with literal
//   expectations followed by randomized traffic, all compared every cycle
//   against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_cksum_checker;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [7:0]  out_syn;
  logic        out_err;
  logic        frm_err;
  logic        err_clr = 1'b0;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic run = 1'b0;
  logic preload_req = 1'b0;

  cksum_checker dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_syn  (out_syn),
    .out_err  (out_err),
    .frm_err  (frm_err),
    .err_clr  (err_clr),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference check function: bit k is the parity of the data bits selected
  // by mask k.
  function automatic logic [7:0] ref_f(input logic [7:0] v);
    logic [7:0] masks [8];
    logic [7:0] r;
    masks[7] = 8'b0010_1100;  // v5 v3 v2
    masks[6] = 8'b1001_0110;  // v7 v4 v2 v1
    masks[5] = 8'b1100_1011;  // v7 v6 v3 v1 v0
    masks[4] = 8'b1100_1001;  // v7 v6 v3 v0
    masks[3] = 8'b1100_1000;  // v7 v6 v3
    masks[2] = 8'b0110_0100;  // v6 v5 v2
    masks[1] = 8'b1011_0010;  // v7 v5 v4 v1
    masks[0] = 8'b0101_1001;  // v6 v4 v3 v0
    for (int k = 0; k < 8; k++) r[k] = ^(v & masks[k]);
    return r;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic        m_held;   // a data byte is waiting for its check byte
  logic [7:0]  m_hold;
  logic        m_ov;
  logic [7:0]  m_od;
  logic [7:0]  m_os;
  logic        m_frm;
  logic [15:0] m_cnt;

  wire m_rdy  = !m_held || !m_ov || out_ready;
  wire m_acc  = in_valid && m_rdy;
  wire m_load = m_acc && !in_first && m_held;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_held <= 1'b0; m_hold <= '0; m_ov <= 1'b0; m_od <= '0; m_os <= '0;
      m_frm <= 1'b0; m_cnt <= '0;
    end else begin
      m_frm <= m_acc && (in_first == m_held);
      if (m_acc) begin
        m_held <= in_first;
        if (in_first) m_hold <= in_byte;
      end
      if (m_load) begin
        m_ov <= 1'b1;
        m_od <= m_hold;
        m_os <= in_byte ^ ref_f(m_hold);
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
`ifdef CHECKER_ERR_CNT_EN
      if (preload_req)  m_cnt <= 16'hFFFE;
      else if (err_clr) m_cnt <= '0;
      else if (m_load && in_byte != ref_f(m_hold) && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
`endif
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (run && nrst) begin
      check("in_ready", in_ready, m_rdy);
      check("out_valid", out_valid, m_ov);
      check("frm_err", frm_err, m_frm);
      if (m_ov) begin
        check("out_data", out_data, m_od);
        check("out_syn", out_syn, m_os);
        check("out_err", out_err, |m_os);
      end
      if (!preload_req) check("err_cnt", err_cnt, m_cnt);
    end
  end

  // Present one beat and hold it until accepted; called at posedge+1,
  // returns at posedge+1 just after the accepting edge.
  task automatic beat(input logic [7:0] b, input logic first);
    logic rdy;
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_first = first; in_byte = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      done = rdy;
    end
    if (!done) check("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_syn", out_syn, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    nrst = 1'b1;
    run  = 1'b1;
    idle(2);

    // Clean codeword.
    beat(8'hFF, 1'b1);
    beat(8'hAC, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hFF);
    check("t1_syn", out_syn, 8'h00);
    check("t1_err", out_err, 0);
    idle(1);

    // Erroneous codeword held under backpressure.
    out_ready = 1'b0;
    beat(8'h01, 1'b1);
    beat(8'h30, 1'b0);
    check("t2_data", out_data, 8'h01);
    check("t2_syn", out_syn, 8'h01);
    check("t2_err", out_err, 1);
`ifdef CHECKER_ERR_CNT_EN
    check("t2_cnt", err_cnt, 16'd1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("t2_clr", err_cnt, 16'd0);
`endif
    beat(8'h00, 1'b1);
    in_valid = 1'b1; in_first = 1'b0; in_byte = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_data", out_data, 8'h01);
      check("bp_hold_syn", out_syn, 8'h01);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 1);
    check("bp_new_data", out_data, 8'h00);
    check("bp_new_syn", out_syn, 8'h00);
    idle(2);

    // Framing: repeated data byte, then lone check byte.
    beat(8'h12, 1'b1);
    beat(8'h34, 1'b1);
    check("fr_pulse", frm_err, 1);
    beat(8'h01, 1'b0);
    check("fr_pulse_gone", frm_err, 0);
    check("fr_data", out_data, 8'h34);
    check("fr_syn", out_syn, 8'h00);
    idle(2);
    beat(8'h55, 1'b0);
    check("lone_pulse", frm_err, 1);
    check("lone_no_out", out_valid, 0);
    idle(2);

    // Reset in the middle of a codeword.
    beat(8'h77, 1'b1);
    #2 nrst = 1'b0;
    #2 nrst = 1'b1;
    idle(1);
    beat(8'hAA, 1'b0);
    check("rst_mid_frm", frm_err, 1);
    check("rst_mid_no_out", out_valid, 0);
    idle(2);

`ifdef CHECKER_ERR_CNT_EN
    // Saturation via backdoor preload.
    force dut.err_cnt_q = 16'hFFFE;
    preload_req = 1'b1;
    idle(1);
    release dut.err_cnt_q;
    preload_req = 1'b0;
    beat(8'h01, 1'b1); beat(8'h30, 1'b0);
    check("sat_ffff", err_cnt, 16'hFFFF);
    beat(8'h01, 1'b1); beat(8'h30, 1'b0);
    check("sat_hold", err_cnt, 16'hFFFF);
    idle(2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic want;
      want      = !m_held;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_first  = ($urandom_range(0, 9) == 0) ? !want : want;
      in_byte   = $urandom_range(0, 255);
      if (!in_first && m_held && $urandom_range(0, 1) == 1) in_byte = ref_f(m_hold);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 49) == 0);
      idle(1);
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cksum_checker.md
# cksum_checker

Receive-side companion to the per-byte XOR check generator. It consumes a byte stream of two-byte codewords (data byte, then check byte) and recomputes the check value from the data byte. It delivers the data byte with a syndrome and error flag through a one-entry registered output stage, with valid/ready backpressure. It sits between the link byte deserializer and the downstream consumer.

## Interface
- No parameters; data width fixed at 8.
- clk  in  1  sole clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_first  in  1  beat is a data byte (1) or check byte (0).
- in_byte  in  8  input byte.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result when out_valid & out_ready.
- out_data  out  8  received data byte.
- out_syn  out  8  syndrome = received check ^ f(data).
- out_err  out  1  |out_syn.
- frm_err  out  1  one-cycle pulse on framing violation.
- err_clr  in  1  synchronous clear of err_cnt (CHECKER_ERR_CNT_EN only).
- err_cnt  out  16  saturating codeword-error count (CHECKER_ERR_CNT_EN only).

## Operation
- Check function f(v), bit by bit. All terms are XORs of input bits.
  - c7 = v3 v2 v5
  - c6 = v2 v1 v4 v7
  - c5 = v1 v7 v0 v3 v6
  - c4 = v7 v0 v3 v6
  - c3 = v3 v7 v6
  - c2 = v2 v6 v5
  - c1 = v1 v5 v4 v7
  - c0 = v0 v4 v3 v6
- States:
  - S_DATA: awaiting a data byte. Reset state.
  - S_CHECK: data byte held in data_q.
- S_DATA, accepted beat:
  - in_first=1: in_byte → data_q; go to S_CHECK.
  - in_first=0: beat dropped; frm_err pulses; stay in S_DATA.
- S_CHECK, accepted beat:
  - in_first=0: load output stage with out_data=data_q, out_syn=in_byte^f(data_q), out_err=|out_syn. Set out_valid. Go to S_DATA.
  - in_first=1: held byte discarded; frm_err pulses; in_byte → data_q; stay in S_CHECK.
- in_ready:
  - S_DATA: 1.
  - S_CHECK: !out_valid | out_ready, so a completed codeword never overwrites an unconsumed result.
- Output stage:
  - out_valid clears on out_ready unless reloaded in the same cycle.
  - out_data, out_syn and out_err are stable while out_valid=1 and out_ready=0.
- Reset values: state=S_DATA, data_q=0, out_valid=0, out_data=0, out_syn=0, out_err=0, frm_err=0, err_cnt=0.
- Reset asserted mid-codeword discards the held byte; no output is produced for it.

## Timing
- Latency: out_valid is high the cycle after the check byte is accepted.
- Throughput: one codeword per two input cycles, sustained with out_ready=1.
- Output transfer and a new load in the same cycle are allowed: the old result is consumed and the new result is registered.
- frm_err is registered, high for exactly the one cycle after the offending beat.
- Framing violations produce no output beat and do not count in err_cnt.

## Configuration
- CHECKER_ERR_CNT_EN defined:
  - err_cnt increments on each output load with out_err=1.
  - err_cnt saturates at 16'hFFFF.
  - err_clr forces err_cnt to 0. If err_clr coincides with an increment, clear wins and the result is 0.
- Not defined:
  - err_cnt tied to 0 and err_clr ignored.
  - No counter flops are instantiated.
  - All other behaviour is identical.

## Test plan
- Reset, then (0xFF, first=1), (0xAC, first=0) → next cycle out_valid=1, out_data=0xFF, out_syn=0x00, out_err=0.
- (0x01, 0x30) → out_data=0x01, out_syn=0x01, out_err=1. With the macro, err_cnt goes 0→1; err_clr then returns it to 0.
- out_ready=0 after one result, then feed a second codeword (0x00, 0x00):
  - the data byte is accepted;
  - in_ready=0 for the check beat;
  - the first result stays stable.
  - Raising out_ready accepts the check beat, and the next cycle shows out_data=0x00.
- Framing: (0x12, first=1), (0x34, first=1), (0xAC ^ f-adjusted check for 0x34, first=0) → one frm_err pulse and a single output for 0x34. A lone first=0 beat in S_DATA → frm_err pulse, no output.
- Saturation: force 65536 erroneous codewords (or preload via a backdoor) → err_cnt holds at 0xFFFF.
- nrst asserted while in S_CHECK → after release, a check-only beat raises frm_err and produces no output.
